vif_draw_resp: RTL

VIF_DRAW_RESP -- requirements
Module: vif_draw_resp

---
 rtl/vif_pkg.sv | 27 ++
 rtl/vif_rdtrack.sv | 60 ++++++
 rtl/vif_draw_resp.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vif_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vif_pkg
// Description : Shared types and widths for the draw-side video memory
//               interface: FSM state encoding, address/data/mask widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vif_pkg;

  localparam int X_W     = 9;
  localparam int Y_W     = 14;
  localparam int ADR_W   = Y_W + X_W;
  localparam int DATA_W  = 64;
  localparam int MASK_W  = 8;
  localparam int BURST_W = 8;
  localparam int RDCNT_W = 4;
  localparam int STALL_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DISP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/vif_rdtrack.sv
`default_nettype none
// ============================================================================
// Module      : vif_rdtrack
// Description : Outstanding-read tracker for the draw port. Counts acked reads
//               against in-order memory returns, flags returns with nothing
//               outstanding, and registers the accepted return data.
// Revision    : 1.0 - initial release
// ============================================================================
module vif_rdtrack
  import vif_pkg::*;
#(
  parameter int MAX_RD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_ack,
  input  logic               mem_rvalid,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [RDCNT_W-1:0] rd_cnt,
  output logic               rd_room,
  output logic               drained,
  output logic               rv_err,
  output logic               rdata_vld,
  output logic [DATA_W-1:0]  rdata
);

  // A return is only accepted if a read is outstanding or being acked in
  // the same cycle; anything else is a stray return and is dropped.
  logic ret_ok;
  assign ret_ok  = mem_rvalid & ((rd_cnt != '0) | rd_ack);
  assign rd_room = (rd_cnt < RDCNT_W'(MAX_RD));
  // Counter reaches zero at the end of this cycle (covers the last return).
  assign drained = (rd_cnt == '0) |
                   ((rd_cnt == RDCNT_W'(1)) & mem_rvalid & !rd_ack);

  // Outstanding count, stray-return flag and the return data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      rv_err    <= 1'b0;
      rdata_vld <= 1'b0;
      rdata     <= '0;
    end else begin
      rdata_vld <= ret_ok;
      if (ret_ok) begin
        rdata <= mem_rdata;
      end
      if (mem_rvalid & !ret_ok) begin
        rv_err <= 1'b1;
      end
      if (rd_ack & !mem_rvalid) begin
        rd_cnt <= rd_cnt + RDCNT_W'(1);
      end else if (!rd_ack & ret_ok) begin
        rd_cnt <= rd_cnt - RDCNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vif_draw_resp.sv
`default_nettype none
// ============================================================================
// Module      : vif_draw_resp
// Description : Arbitrates a single memory command port between the drawing
//               engine and display fetch. Draw commands are passed through
//               combinationally; display is granted the port after draw reads
//               drain, with a bounded draw burst while display is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module vif_draw_resp
  import vif_pkg::*;
#(
  parameter int BURST_MAX = 32,
  parameter int MAX_RD    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DRW_VRAMREQ,
  input  logic              DRW_VRAMWRITE,
  input  logic [ADR_W-1:0]  DRW_VRAMADR,
  input  logic [MASK_W-1:0] DRW_VRAMDMASK,
  input  logic [DATA_W-1:0] DRW_VRAMWDATA,
  output logic              VIF_DRWACK,
  output logic              VIF_DRWRDATAVLD,
  output logic [DATA_W-1:0] VIF_DRWRDATA,
  input  logic              DISP_REQ,
  output logic              DISP_GNT,
  input  logic              MEM_READY,
  output logic              MEM_CMD,
  output logic              MEM_WE,
  output logic [ADR_W-1:0]  MEM_ADR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [MASK_W-1:0] MEM_DMASK,
  input  logic              MEM_RVALID,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [1:0]        ERROR
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(BURST_MAX);

  state_t              state;
  state_t              state_nxt;
  logic [BURST_W-1:0]  burst;
  logic [STALL_W-1:0]  stall;
  logic                stall_err;
  logic [RDCNT_W-1:0]  rd_cnt;
  logic                rd_room;
  logic                drained;
  logic                rv_err;
  logic                burst_full;
  logic                ack;
  logic                rd_ack;

  // Display has waited long enough: stop accepting draw commands.
  assign burst_full = DISP_REQ & (burst == BURST_LIM);
  assign ack        = (state == ST_DRAW) & DRW_VRAMREQ & MEM_READY &
                      (DRW_VRAMWRITE | rd_room) & !burst_full;
  assign rd_ack     = ack & !DRW_VRAMWRITE;

  assign VIF_DRWACK = ack;
  assign MEM_CMD    = ack;
  assign MEM_WE     = ack & DRW_VRAMWRITE;
  assign MEM_ADR    = ack ? DRW_VRAMADR   : '0;
  assign MEM_WDATA  = ack ? DRW_VRAMWDATA : '0;
  assign MEM_DMASK  = ack ? DRW_VRAMDMASK : '0;
  assign ERROR      = {stall_err, rv_err};

  vif_rdtrack #(
    .MAX_RD (MAX_RD)
  ) u_rdtrack (
    .clk        (CLK),
    .rst        (RST),
    .rd_ack     (rd_ack),
    .mem_rvalid (MEM_RVALID),
    .mem_rdata  (MEM_RDATA),
    .rd_cnt     (rd_cnt),
    .rd_room    (rd_room),
    .drained    (drained),
    .rv_err     (rv_err),
    .rdata_vld  (VIF_DRWRDATAVLD),
    .rdata      (VIF_DRWRDATA)
  );

  // State register; the display grant is a flop that tracks the DISP state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      DISP_GNT <= 1'b0;
    end else begin
      state    <= state_nxt;
      DISP_GNT <= (state_nxt == ST_DISP);
    end
  end

  // Next-state logic; display wins ties from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (DISP_REQ) begin
          state_nxt = ST_DISP;
        end else if (DRW_VRAMREQ) begin
          state_nxt = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (DISP_REQ & ((burst == BURST_LIM) | !DRW_VRAMREQ)) begin
          state_nxt = ST_DRAIN;
        end else if (!DRW_VRAMREQ & !DISP_REQ) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (drained) begin
          state_nxt = ST_DISP;
        end
      end
      ST_DISP: begin
        if (!DISP_REQ) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Burst counter: zero outside DRAW, saturating count of acks inside it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      burst <= '0;
    end else if (state != ST_DRAW) begin
      burst <= '0;
    end else if (ack & (burst != '1)) begin
      burst <= burst + BURST_W'(1);
    end
  end

  // Stall watchdog: a request left unacked for 1024 cycles is flagged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall     <= '0;
      stall_err <= 1'b0;
    end else if (DRW_VRAMREQ & !ack) begin
      stall <= stall + STALL_W'(1);
      if (stall == '1) begin
        stall_err <= 1'b1;
      end
    end else begin
      stall <= '0;
    end
  end

endmodule
`default_nettype wire
